// File: rtl/controlador_serial_somsub_if.sv
// Word-level request/response bundle for the bit-serial adder/subtractor controller.
// The requester drives the master side and the controller drives the slave side.
interface controlador_serial_somsub_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic         M;
  logic [N-1:0] A_in;
  logic [N-1:0] B_in;
  logic [N-1:0] S_out;
  logic         Ts_out;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, M, A_in, B_in,
    input  S_out, Ts_out, ovf, busy, done
  );

  modport slave (
    input  start, M, A_in, B_in,
    output S_out, Ts_out, ovf, busy, done
  );
endinterface

// File: rtl/controlador_serial_somsub.sv
// Bit-serial N-bit adder/subtractor controller: drives a single 1-bit full adder/subtractor
// cell over N cycles, LSB first, then reports carry/borrow, signed overflow and a done pulse.
module controlador_serial_somsub #(
  parameter int unsigned N = 8
) (
  input logic                          clk,
  input logic                          rst,
  controlador_serial_somsub_if.slave   bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   s_q, s_d;
  logic           mode_q, mode_d;
  logic           carry_q, carry_d;
  logic           ts_q, ts_d;
  logic           ovf_q, ovf_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // 1-bit full adder/subtractor cell
  logic cell_a, cell_b, cell_s, cell_ts;
  assign cell_a = a_q[0];
  assign cell_b = b_q[0];
  assign cell_s = cell_a ^ cell_b ^ carry_q;

  always_comb begin
    if (mode_q) begin
      cell_ts = (~cell_a & cell_b) | (carry_q & ~(cell_a ^ cell_b));
    end else begin
      cell_ts = (cell_a & cell_b) | (carry_q & (cell_a ^ cell_b));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      ts_q    <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    ts_d    = ts_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A_in;
          b_d     = bus.B_in;
          mode_d  = bus.M;
          a_msb_d = bus.A_in[N-1];
          b_msb_d = bus.B_in[N-1];
          carry_d = 1'b0;
          cnt_d   = '0;
          s_d     = '0;
          ts_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        carry_d = cell_ts;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = {cell_s, s_q[N-1:1]};
        if (cnt_q == CntLast) begin
          ts_d    = cell_ts;
          // Overflow uses the MSBs captured at start, since the operand registers have shifted.
          if (mode_q) begin
            ovf_d = (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
          end else begin
            ovf_d = (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.S_out  = s_q;
  assign bus.Ts_out = ts_q;
  assign bus.ovf    = ovf_q;
  assign bus.busy   = (state_q == StCalc);
  assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_controlador_serial_somsub.sv
// Directed bench for controlador_serial_somsub (N=8): table-driven operations plus
// hand-written sequences for ignored start, mid-operation reset and back-to-back starts.
module tb_controlador_serial_somsub;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;

  controlador_serial_somsub_if #(.N(N)) bus ();

  controlador_serial_somsub #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  typedef struct {
    string        name;
    logic         m;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         ts;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation, wait for done (bounded), then check results and the release cycle.
  task automatic run_op(input vec_t v);
    int busy_cnt;
    int i;
    @(negedge clk);
    bus.start = 1'b1;
    bus.M     = v.m;
    bus.A_in  = v.a;
    bus.B_in  = v.b;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    i         = 0;
    while (!bus.done && i < 40) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      i++;
    end
    check({v.name, " done_seen"}, 32'(bus.done), 32'd1);
    check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'(N));
    check({v.name, " S_out"}, 32'(bus.S_out), 32'(v.s));
    check({v.name, " Ts_out"}, 32'(bus.Ts_out), 32'(v.ts));
    check({v.name, " ovf"}, 32'(bus.ovf), 32'(v.ovf));
    check({v.name, " busy_in_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({v.name, " done_fall"}, 32'(bus.done), 32'd0);
    check({v.name, " S_hold"}, 32'(bus.S_out), 32'(v.s));
  endtask

  initial begin
    int done_cnt;
    int busy_after;
    int seen_done;
    logic [N-1:0] s_cap;
    int last_done;
    int gap_bad;
    int val_bad;
    vec_t v;

    vecs.push_back('{"add_2d_1c", 1'b0, 8'h2D, 8'h1C, 8'h49, 1'b0, 1'b0});
    vecs.push_back('{"add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{"add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0});
    vecs.push_back('{"sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1});
    vecs.push_back('{"add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{"sub_7f_ff", 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1});

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.M     = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset S_out", 32'(bus.S_out), 32'd0);
    check("reset Ts_out", 32'(bus.Ts_out), 32'd0);
    check("reset ovf", 32'(bus.ovf), 32'd0);

    foreach (vecs[k]) run_op(vecs[k]);

    // Start and input changes during CALC must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.M = 1'b0; bus.A_in = 8'h10; bus.B_in = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A_in = 8'hFF; bus.M = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0; busy_after = 0; seen_done = 0; s_cap = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        done_cnt++;
        seen_done = 1;
        s_cap = bus.S_out;
      end else if (seen_done != 0 && bus.busy) begin
        busy_after = 1;
      end
      @(negedge clk);
    end
    check("ignore done_count", 32'(done_cnt), 32'd1);
    check("ignore S_out", 32'(s_cap), 32'h30);
    check("ignore busy_after", 32'(busy_after), 32'd0);

    // Reset on the third CALC cycle aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.M = 1'b0; bus.A_in = 8'h55; bus.B_in = 8'h33;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort S_out", 32'(bus.S_out), 32'd0);
    check("abort Ts_out", 32'(bus.Ts_out), 32'd0);
    check("abort ovf", 32'(bus.ovf), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) done_cnt++;
      @(negedge clk);
    end
    check("abort no_activity", 32'(done_cnt), 32'd0);
    v = '{"after_abort", 1'b0, 8'h55, 8'h33, 8'h88, 1'b0, 1'b1};
    run_op(v);

    // start held high: a done pulse every N+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.M = 1'b1; bus.A_in = 8'h00; bus.B_in = 8'h01;
    done_cnt = 0; last_done = -1; gap_bad = 0; val_bad = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last_done >= 0 && (i - last_done) != int'(N + 2)) gap_bad++;
        if (bus.S_out !== 8'hFF || bus.Ts_out !== 1'b1 || bus.ovf !== 1'b0) val_bad++;
        last_done = i;
        done_cnt++;
      end
    end
    bus.start = 1'b0;
    check("b2b done_count", 32'(done_cnt), 32'd3);
    check("b2b spacing_errs", 32'(gap_bad), 32'd0);
    check("b2b value_errs", 32'(val_bad), 32'd0);
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
